// File: rtl/crop_frame_sequencer.sv
// Per-frame sequencer ahead of the crop + CNN pipeline: takes one clamped crop request,
// streams its coordinates, gates one frame of pixels and waits for ap_done.
// Optional watchdog in WAIT_DONE is enabled by defining CROP_SEQ_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | waiting for a crop request (req_ready high)
// SEND_COORD | crop_Y1/crop_X1 beats outstanding, ap_start high
// STREAM     | pixel gate open until one full frame has passed
// WAIT_DONE  | frame delivered, waiting for ap_done (or latched early done)
// FRAME_DONE | one-cycle completion pulse, frame counter bump
module crop_frame_sequencer #(
    parameter int PIXEL_BIT_WIDTH  = 12,
    parameter int IN_ROWS          = 40,
    parameter int IN_COLS          = 40,
    parameter int OUT_ROWS         = 20,
    parameter int OUT_COLS         = 20,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10,
    parameter int FRAME_CNT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [IMG_ROW_BITWIDTH-1:0] req_y1,
    input  logic [IMG_COL_BITWIDTH-1:0] req_x1,
    output logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
    output logic                        crop_Y1_TVALID,
    input  logic                        crop_Y1_TREADY,
    output logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA,
    output logic                        crop_X1_TVALID,
    input  logic                        crop_X1_TREADY,
    input  logic [PIXEL_BIT_WIDTH-1:0]  src_TDATA,
    input  logic                        src_TVALID,
    output logic                        src_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0]  img_input_TDATA,
    output logic                        img_input_TVALID,
    input  logic                        img_input_TREADY,
    output logic                        ap_start,
    input  logic                        ap_done,
    output logic                        busy,
    output logic                        frame_done,
    output logic [FRAME_CNT_WIDTH-1:0]  frame_count,
    output logic                        clamp_flag,
    output logic                        timeout_err
);

    localparam int NPIX  = IN_ROWS * IN_COLS;
    localparam int PIX_W = $clog2(NPIX);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
    localparam logic [IMG_ROW_BITWIDTH-1:0] Y1_MAX = IMG_ROW_BITWIDTH'(IN_ROWS - OUT_ROWS);
    localparam logic [IMG_COL_BITWIDTH-1:0] X1_MAX = IMG_COL_BITWIDTH'(IN_COLS - OUT_COLS);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SEND_COORD = 3'd1;
    localparam logic [2:0] S_STREAM     = 3'd2;
    localparam logic [2:0] S_WAIT_DONE  = 3'd3;
    localparam logic [2:0] S_FRAME_DONE = 3'd4;

    logic [2:0]                  state_q, state_d;
    logic [IMG_ROW_BITWIDTH-1:0] y1_q, y1_d;
    logic [IMG_COL_BITWIDTH-1:0] x1_q, x1_d;
    logic                        y_vld_q, y_vld_d;
    logic                        x_vld_q, x_vld_d;
    logic                        ap_start_q, ap_start_d;
    logic                        clamp_q, clamp_d;
    logic                        done_seen_q, done_seen_d;
    logic [PIX_W-1:0]            pix_cnt_q, pix_cnt_d;
    logic [FRAME_CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
    logic                        gate;
    logic                        pix_hs;

`ifdef CROP_SEQ_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timeout_q, timeout_d;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign gate             = (state_q == S_STREAM);
    assign img_input_TVALID = src_TVALID & gate;
    assign src_TREADY       = img_input_TREADY & gate;
    assign img_input_TDATA  = src_TDATA;
    assign pix_hs           = img_input_TVALID & img_input_TREADY;

    assign req_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign frame_done     = (state_q == S_FRAME_DONE);
    assign crop_Y1_TDATA  = y1_q;
    assign crop_X1_TDATA  = x1_q;
    assign crop_Y1_TVALID = y_vld_q;
    assign crop_X1_TVALID = x_vld_q;
    assign ap_start       = ap_start_q;
    assign frame_count    = frame_cnt_q;
    assign clamp_flag     = clamp_q;

    always_comb begin
        state_d     = state_q;
        y1_d        = y1_q;
        x1_d        = x1_q;
        y_vld_d     = y_vld_q;
        x_vld_d     = x_vld_q;
        ap_start_d  = ap_start_q;
        clamp_d     = clamp_q;
        done_seen_d = done_seen_q;
        pix_cnt_d   = pix_cnt_q;
        frame_cnt_d = frame_cnt_q;
`ifdef CROP_SEQ_TIMEOUT_EN
        tmr_d       = tmr_q;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    y1_d        = (req_y1 > Y1_MAX) ? Y1_MAX : req_y1;
                    x1_d        = (req_x1 > X1_MAX) ? X1_MAX : req_x1;
                    clamp_d     = (req_y1 > Y1_MAX) | (req_x1 > X1_MAX);
                    y_vld_d     = 1'b1;
                    x_vld_d     = 1'b1;
                    ap_start_d  = 1'b1;
                    done_seen_d = 1'b0;
                    pix_cnt_d   = '0;
                    state_d     = S_SEND_COORD;
                end
            end
            S_SEND_COORD: begin
                if (crop_Y1_TREADY) y_vld_d = 1'b0;
                if (crop_X1_TREADY) x_vld_d = 1'b0;
                // Both beats done (earlier or on this edge) releases the pixel gate next cycle.
                if ((!y_vld_q || crop_Y1_TREADY) && (!x_vld_q || crop_X1_TREADY))
                    state_d = S_STREAM;
                if (ap_done) done_seen_d = 1'b1;
            end
            S_STREAM: begin
                if (pix_hs) begin
                    if (pix_cnt_q == PIX_LAST) begin
                        pix_cnt_d = '0;
                        state_d   = S_WAIT_DONE;
`ifdef CROP_SEQ_TIMEOUT_EN
                        tmr_d     = TMR_LOAD;
`endif
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
                if (ap_done) done_seen_d = 1'b1;
            end
            S_WAIT_DONE: begin
                if (ap_done || done_seen_q) begin
                    ap_start_d = 1'b0;
                    state_d    = S_FRAME_DONE;
                end
`ifdef CROP_SEQ_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    timeout_d  = 1'b1;
                    ap_start_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
`endif
            end
            S_FRAME_DONE: begin
                frame_cnt_d = frame_cnt_q + 1'b1;
                done_seen_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= S_IDLE;
            y1_q        <= '0;
            x1_q        <= '0;
            y_vld_q     <= 1'b0;
            x_vld_q     <= 1'b0;
            ap_start_q  <= 1'b0;
            clamp_q     <= 1'b0;
            done_seen_q <= 1'b0;
            pix_cnt_q   <= '0;
            frame_cnt_q <= '0;
`ifdef CROP_SEQ_TIMEOUT_EN
            tmr_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            y1_q        <= y1_d;
            x1_q        <= x1_d;
            y_vld_q     <= y_vld_d;
            x_vld_q     <= x_vld_d;
            ap_start_q  <= ap_start_d;
            clamp_q     <= clamp_d;
            done_seen_q <= done_seen_d;
            pix_cnt_q   <= pix_cnt_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef CROP_SEQ_TIMEOUT_EN
            tmr_q       <= tmr_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_crop_frame_sequencer.sv
// Self-checking bench for crop_frame_sequencer: randomized pixel/handshake traffic
// against a frame-level reference model (clamp rule, 1600-pixel budget, frame counting).
module tb_crop_frame_sequencer;

    localparam int PW = 12, RW = 10, CW = 10, FW = 16;
    localparam int NPIX = 40 * 40;
    localparam int YMAX = 40 - 20, XMAX = 40 - 20;
    localparam int TO = 100;

    logic          ap_clk, ap_rst_n;
    logic          req_valid, req_ready;
    logic [RW-1:0] req_y1;
    logic [CW-1:0] req_x1;
    logic [RW-1:0] crop_Y1_TDATA;
    logic          crop_Y1_TVALID, crop_Y1_TREADY;
    logic [CW-1:0] crop_X1_TDATA;
    logic          crop_X1_TVALID, crop_X1_TREADY;
    logic [PW-1:0] src_TDATA, img_input_TDATA;
    logic          src_TVALID, src_TREADY, img_input_TVALID, img_input_TREADY;
    logic          ap_start, ap_done, busy, frame_done, clamp_flag, timeout_err;
    logic [FW-1:0] frame_count;

    crop_frame_sequencer #(
        .PIXEL_BIT_WIDTH(PW), .IN_ROWS(40), .IN_COLS(40), .OUT_ROWS(20), .OUT_COLS(20),
        .IMG_ROW_BITWIDTH(RW), .IMG_COL_BITWIDTH(CW), .FRAME_CNT_WIDTH(FW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_y1(req_y1), .req_x1(req_x1),
        .crop_Y1_TDATA(crop_Y1_TDATA), .crop_Y1_TVALID(crop_Y1_TVALID), .crop_Y1_TREADY(crop_Y1_TREADY),
        .crop_X1_TDATA(crop_X1_TDATA), .crop_X1_TVALID(crop_X1_TVALID), .crop_X1_TREADY(crop_X1_TREADY),
        .src_TDATA(src_TDATA), .src_TVALID(src_TVALID), .src_TREADY(src_TREADY),
        .img_input_TDATA(img_input_TDATA), .img_input_TVALID(img_input_TVALID),
        .img_input_TREADY(img_input_TREADY),
        .ap_start(ap_start), .ap_done(ap_done), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count), .clamp_flag(clamp_flag), .timeout_err(timeout_err)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_pass = 0, n_total = 0;
    int m_frames = 0;
    logic m_clamp = 1'b0, m_timeout = 1'b0;
    logic [RW-1:0] m_y1 = '0;
    logic [CW-1:0] m_x1 = '0;

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic quiet_inputs;
        req_valid = 0; req_y1 = '0; req_x1 = '0;
        crop_Y1_TREADY = 0; crop_X1_TREADY = 0;
        src_TVALID = 0; src_TDATA = '0; img_input_TREADY = 0; ap_done = 0;
    endtask

    task automatic model_reset;
        m_frames = 0; m_clamp = 0; m_timeout = 0; m_y1 = '0; m_x1 = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_total++;
        if ({crop_Y1_TVALID, crop_X1_TVALID, ap_start, busy, frame_done, clamp_flag,
             timeout_err, src_TREADY, img_input_TVALID} !== 9'b0 ||
            frame_count !== '0 || crop_Y1_TDATA !== '0 || crop_X1_TDATA !== '0)
            $display("FAIL %s: vld=%b%b start=%b busy=%b fd=%b clamp=%b to=%b srdy=%b ivld=%b cnt=%0d y=%0d x=%0d, want all zero",
                     tag, crop_Y1_TVALID, crop_X1_TVALID, ap_start, busy, frame_done, clamp_flag,
                     timeout_err, src_TREADY, img_input_TVALID, frame_count, crop_Y1_TDATA, crop_X1_TDATA);
        else n_pass++;
    endtask

    task automatic test_reset;
        quiet_inputs();
        ap_rst_n = 0;
        src_TVALID = 1; img_input_TREADY = 1; crop_Y1_TREADY = 1; crop_X1_TREADY = 1;
        tick(); tick();
        model_reset();
        check_reset_outputs("reset_state");
        ap_rst_n = 1;
        quiet_inputs();
        tick();
    endtask

    task automatic do_request(input int y, input int x);
        req_y1 = RW'(y); req_x1 = CW'(x); req_valid = 1;
        #1;
        n_total++;
        if ({req_ready, busy} !== 2'b10)
            $display("FAIL req_idle: ready=%b busy=%b, want 1 0", req_ready, busy);
        else n_pass++;
        tick();
        req_valid = 0; req_y1 = RW'($urandom); req_x1 = CW'($urandom);
        m_y1 = RW'((y > YMAX) ? YMAX : y);
        m_x1 = CW'((x > XMAX) ? XMAX : x);
        m_clamp = (y > YMAX) || (x > XMAX);
        n_total++;
        if ({crop_Y1_TVALID, crop_X1_TVALID, ap_start, busy, req_ready} !== 5'b11110)
            $display("FAIL req_accept: yv=%b xv=%b start=%b busy=%b ready=%b, want 1 1 1 1 0",
                     crop_Y1_TVALID, crop_X1_TVALID, ap_start, busy, req_ready);
        else n_pass++;
        n_total++;
        if (crop_Y1_TDATA !== m_y1 || crop_X1_TDATA !== m_x1 || clamp_flag !== m_clamp)
            $display("FAIL req_clamp(%0d,%0d): y=%0d x=%0d clamp=%b, want y=%0d x=%0d clamp=%b",
                     y, x, crop_Y1_TDATA, crop_X1_TDATA, clamp_flag, m_y1, m_x1, m_clamp);
        else n_pass++;
    endtask

    task automatic do_coord(input int yd, input int xd);
        logic yp, xp;
        yp = 1; xp = 1;
        src_TVALID = 1; img_input_TREADY = 1; src_TDATA = PW'($urandom);
        for (int c = 0; c < 200 && (yp || xp); c++) begin
            crop_Y1_TREADY = (c >= yd);
            crop_X1_TREADY = (c >= xd);
            #1;
            n_total++;
            if ({crop_Y1_TVALID, crop_X1_TVALID} !== {yp, xp} ||
                {src_TREADY, img_input_TVALID, ap_start} !== 3'b001 ||
                crop_Y1_TDATA !== m_y1 || crop_X1_TDATA !== m_x1)
                $display("FAIL coord_cycle%0d: yv=%b xv=%b srdy=%b ivld=%b start=%b y=%0d x=%0d, want yv=%b xv=%b 0 0 1 y=%0d x=%0d",
                         c, crop_Y1_TVALID, crop_X1_TVALID, src_TREADY, img_input_TVALID, ap_start,
                         crop_Y1_TDATA, crop_X1_TDATA, yp, xp, m_y1, m_x1);
            else n_pass++;
            if (crop_Y1_TREADY) yp = 0;
            if (crop_X1_TREADY) xp = 0;
            tick();
        end
        crop_Y1_TREADY = 0; crop_X1_TREADY = 0;
        #1;
        n_total++;
        if ((yp || xp) || {src_TREADY, crop_Y1_TVALID, crop_X1_TVALID} !== 3'b100)
            $display("FAIL stream_entry: srdy=%b yv=%b xv=%b pending=%b%b, want 1 0 0 00",
                     src_TREADY, crop_Y1_TVALID, crop_X1_TVALID, yp, xp);
        else n_pass++;
    endtask

    task automatic do_stream(input int stop_at, input int done_at);
        int pix;
        logic done_sent;
        pix = 0; done_sent = 0;
        for (int c = 0; c < 20000 && pix < stop_at; c++) begin
            src_TVALID = ($urandom_range(0, 3) != 0);
            src_TDATA = PW'($urandom);
            img_input_TREADY = ($urandom_range(0, 3) != 0);
            ap_done = (pix == done_at) && !done_sent;
            if (ap_done) done_sent = 1;
            #1;
            n_total++;
            if ({img_input_TVALID, src_TREADY} !== {src_TVALID, img_input_TREADY} ||
                img_input_TDATA !== src_TDATA || {ap_start, busy} !== 2'b11)
                $display("FAIL stream_pix%0d: ivld=%b srdy=%b data=%h start=%b busy=%b, want ivld=%b srdy=%b data=%h 1 1",
                         pix, img_input_TVALID, src_TREADY, img_input_TDATA, ap_start, busy,
                         src_TVALID, img_input_TREADY, src_TDATA);
            else n_pass++;
            if (src_TVALID && img_input_TREADY) pix++;
            tick();
        end
        ap_done = 0;
        n_total++;
        if (pix != stop_at) $display("FAIL stream_budget: pixels=%0d, want %0d", pix, stop_at);
        else n_pass++;
    endtask

    task automatic check_gated(input string tag);
        src_TVALID = 1; img_input_TREADY = 1;
        #1;
        n_total++;
        if ({src_TREADY, img_input_TVALID, busy, frame_done} !== 4'b0010)
            $display("FAIL %s: srdy=%b ivld=%b busy=%b fd=%b, want 0 0 1 0",
                     tag, src_TREADY, img_input_TVALID, busy, frame_done);
        else n_pass++;
    endtask

    task automatic do_finish(input logic early, input int wait_cyc);
        check_gated("post_frame_gate");
        if (!early) begin
            for (int k = 0; k < wait_cyc; k++) begin
                tick();
                n_total++;
                if ({frame_done, busy, ap_start, src_TREADY, timeout_err} !== {4'b0110, 1'b0} )
                    $display("FAIL wait_done%0d: fd=%b busy=%b start=%b srdy=%b to=%b, want 0 1 1 0 0",
                             k, frame_done, busy, ap_start, src_TREADY, timeout_err);
                else n_pass++;
            end
            ap_done = 1;
            tick();
            ap_done = 0;
        end else begin
            tick();
        end
        m_frames++;
        n_total++;
        if ({frame_done, ap_start, busy} !== 3'b101)
            $display("FAIL frame_done_pulse: fd=%b start=%b busy=%b, want 1 0 1", frame_done, ap_start, busy);
        else n_pass++;
        tick();
        n_total++;
        if ({frame_done, busy, req_ready} !== 3'b001 || frame_count !== FW'(m_frames) ||
            timeout_err !== m_timeout || clamp_flag !== m_clamp)
            $display("FAIL frame_end: fd=%b busy=%b ready=%b cnt=%0d to=%b clamp=%b, want 0 0 1 cnt=%0d to=%b clamp=%b",
                     frame_done, busy, req_ready, frame_count, timeout_err, clamp_flag,
                     m_frames, m_timeout, m_clamp);
        else n_pass++;
        src_TVALID = 0; img_input_TREADY = 0;
    endtask

    task automatic run_frame(input int y, input int x, input int yd, input int xd, input int wait_cyc);
        do_request(y, x);
        do_coord(yd, xd);
        do_stream(NPIX, -1);
        do_finish(1'b0, wait_cyc);
    endtask

    task automatic test_basic;
        run_frame(5, 7, 0, 0, 3);
    endtask

    task automatic test_clamp;
        run_frame(30, 25, 1, 2, 1);
        run_frame(3, 3, 0, 0, 0);
        run_frame(20, 21, 2, 0, 2);
    endtask

    task automatic test_x1_stall;
        run_frame(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 0, 10, 2);
    endtask

    task automatic test_early_done;
        do_request(10, 12);
        do_coord(1, 1);
        do_stream(NPIX, 1000);
        do_finish(1'b1, 0);
    endtask

    task automatic test_random_frames;
        for (int f = 0; f < 4; f++)
            run_frame(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 8)));
    endtask

    task automatic test_timeout;
`ifdef CROP_SEQ_TIMEOUT_EN
        do_request(4, 4);
        do_coord(0, 0);
        do_stream(NPIX, -1);
        check_gated("timeout_gate");
        for (int k = 1; k < TO; k++) begin
            tick();
            n_total++;
            if ({busy, timeout_err, frame_done, ap_start} !== 4'b1001)
                $display("FAIL timeout_wait%0d: busy=%b to=%b fd=%b start=%b, want 1 0 0 1",
                         k, busy, timeout_err, frame_done, ap_start);
            else n_pass++;
        end
        tick();
        m_timeout = 1;
        n_total++;
        if ({busy, timeout_err, frame_done, ap_start, req_ready} !== 5'b01001 ||
            frame_count !== FW'(m_frames))
            $display("FAIL timeout_fire: busy=%b to=%b fd=%b start=%b ready=%b cnt=%0d, want 0 1 0 0 1 cnt=%0d",
                     busy, timeout_err, frame_done, ap_start, req_ready, frame_count, m_frames);
        else n_pass++;
        src_TVALID = 0; img_input_TREADY = 0;
        run_frame(8, 9, 0, 0, 1);
`else
        run_frame(8, 9, 0, 0, 150);
`endif
    endtask

    task automatic test_reset_midframe;
        do_request(35, 2);
        do_coord(0, 0);
        do_stream(800, -1);
        ap_rst_n = 0;
        src_TVALID = 1; img_input_TREADY = 1;
        tick();
        model_reset();
        check_reset_outputs("midframe_reset");
        ap_rst_n = 1;
        quiet_inputs();
        tick();
        run_frame(6, 1, 0, 0, 2);
    endtask

    initial begin
        quiet_inputs();
        ap_rst_n = 0;
        test_reset();
        test_basic();
        test_clamp();
        test_x1_stall();
        test_early_done();
        test_random_frames();
        test_timeout();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
